mdr_mem_if: RTL and testbench

- Parametrised successor to the datapath memory data register.
- Holds the word exchanged between the bus and memory. Adds a request/ready memory handshake with wait-state timeout, plus byte/halfword/word access sizes.
- Loads use lane selection and sign/zero extension; stores use lane replication with byte enables.
- Sits between the internal bus (BMout in, BMInMDR out) and the memory chip, driven by the control unit.

---
 rtl/mdr_mem_if_pkg.sv | 23 ++
 rtl/mdr_mem_if_lane_align.sv | 81 ++++++++
 rtl/mdr_mem_if.sv | 169 ++++++++++++++++
 tb/tb_mdr_mem_if.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdr_mem_if_pkg.sv
// Shared definitions for the memory data register: access size encodings,
// FSM state encoding and the wait-counter width.
package mdr_mem_if_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Wide enough for any MAX_WAIT in 1..255
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10
  } state_e;

  // Both 10 and 11 select a full-word access
  function automatic logic is_word(input logic [1:0] sz);
    return sz[1];
  endfunction

endpackage

// File: rtl/mdr_mem_if_lane_align.sv
// Combinational lane handling: load extract/extend from the memory word and
// store replication plus byte-enable generation.
module mdr_lane_align
  import mdr_mem_if_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANE_W = 2
) (
  input  logic [DATA_W-1:0]   ld_data,
  input  logic [1:0]          ld_size,
  input  logic                ld_sign,
  input  logic [LANE_W-1:0]   ld_addr,
  output logic [DATA_W-1:0]   ld_value,
  input  logic [DATA_W-1:0]   st_data,
  input  logic [1:0]          st_size,
  input  logic [LANE_W-1:0]   st_addr,
  output logic [DATA_W-1:0]   st_wdata,
  output logic [DATA_W/8-1:0] st_be
);

  localparam int BE_W = DATA_W / 8;

  logic [LANE_W-1:0] ld_half_addr;
  logic [LANE_W-1:0] st_half_addr;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] byte_rep;
  logic [DATA_W-1:0] half_rep;

  // Halfword lanes are forced even so the part select never leaves the word
  assign ld_half_addr = {ld_addr[LANE_W-1:1], 1'b0};
  assign st_half_addr = {st_addr[LANE_W-1:1], 1'b0};

  assign ld_byte = ld_data[{ld_addr, 3'b000} +: 8];
  assign ld_half = ld_data[{ld_half_addr, 3'b000} +: 16];

  always_comb begin
    ld_value = ld_data;
    case (ld_size)
      SZ_BYTE: ld_value = {{(DATA_W-8){ld_sign & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_value = {{(DATA_W-16){ld_sign & ld_half[15]}}, ld_half};
      SZ_WORD, 2'b11: ld_value = ld_data;
      default: ld_value = ld_data;
    endcase
  end

  always_comb begin
    byte_rep = '0;
    half_rep = '0;
    for (int i = 0; i < BE_W; i++) begin
      byte_rep[8*i +: 8] = st_data[7:0];
    end
    for (int i = 0; i < DATA_W/16; i++) begin
      half_rep[16*i +: 16] = st_data[15:0];
    end
  end

  always_comb begin
    st_wdata = st_data;
    st_be    = '1;
    case (st_size)
      SZ_BYTE: begin
        st_wdata = byte_rep;
        st_be    = BE_W'(1) << st_addr;
      end
      SZ_HALF: begin
        st_wdata = half_rep;
        st_be    = BE_W'(3) << st_half_addr;
      end
      SZ_WORD, 2'b11: begin
        st_wdata = st_data;
        st_be    = '1;
      end
      default: begin
        st_wdata = st_data;
        st_be    = '1;
      end
    endcase
  end

endmodule

// File: rtl/mdr_mem_if.sv
// Memory data register with request/ready handshake, wait-state timeout and
// byte/halfword/word accesses; keeps the legacy MDRin load path in IDLE.
module mdr_mem_if
  import mdr_mem_if_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int                MAX_WAIT  = 15,
  localparam int               LANE_W    = $clog2(DATA_W/8),
  localparam int               BE_W      = DATA_W/8
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              MDRin,
  input  logic              read,
  input  logic [DATA_W-1:0] BMout,
  input  logic [DATA_W-1:0] Mdatain,
  input  logic              start_rd,
  input  logic              start_wr,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [LANE_W-1:0] addr_lo,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] BMInMDR,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] reg_q, reg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic [1:0]        size_q, size_d;
  logic              sign_q, sign_d;
  logic [LANE_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;

  logic [DATA_W-1:0] ld_value;
  logic [DATA_W-1:0] st_wdata;
  logic [BE_W-1:0]   st_be;
  logic              misaligned;
  logic [CNT_W:0]    cnt_inc;
  logic              timeout;

  // Loads use the attributes captured at start; stores use the live ones
  // because wdata/be are registered on the start edge itself.
  mdr_lane_align #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W)
  ) u_lane_align (
    .ld_data  (Mdatain),
    .ld_size  (size_q),
    .ld_sign  (sign_q),
    .ld_addr  (addr_q),
    .ld_value (ld_value),
    .st_data  (reg_q),
    .st_size  (size),
    .st_addr  (addr_lo),
    .st_wdata (st_wdata),
    .st_be    (st_be)
  );

  assign misaligned = is_word(size) ? (addr_lo != '0)
                                    : ((size == SZ_HALF) && addr_lo[0]);

  assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign timeout = (cnt_inc == (CNT_W+1)'(MAX_WAIT));

  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = 1'b0;
    size_d  = size_q;
    sign_d  = sign_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;

    case (state_q)
      ST_IDLE: begin
        if (start_rd || start_wr) begin
          if (misaligned) begin
            err_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            cnt_d   = '0;
            size_d  = size;
            sign_d  = sign_ext;
            addr_d  = addr_lo;
            if (start_rd) begin
              state_d = ST_RD;
            end else begin
              state_d = ST_WR;
              wdata_d = st_wdata;
              be_d    = st_be;
            end
          end
        end else if (MDRin) begin
          reg_d = read ? Mdatain : BMout;
        end
      end

      ST_RD, ST_WR: begin
        // Ready is checked first so it wins over a simultaneous timeout
        if (mem_ready) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
          if (state_q == ST_RD) begin
            reg_d = ld_value;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= ST_IDLE;
      reg_q   <= RESET_VAL;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      size_q  <= SZ_BYTE;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  assign BMInMDR    = reg_q;
  assign mem_wdata  = wdata_q;
  assign mem_be     = (state_q == ST_WR) ? be_q : '0;
  assign mem_rd_req = (state_q == ST_RD);
  assign mem_wr_req = (state_q == ST_WR);
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mdr_mem_if.sv
// Directed self-checking bench for mdr_mem_if (DATA_W=32, RESET_VAL=2, MAX_WAIT=15).
module tb_mdr_mem_if;

  logic        clock;
  logic        clear;
  logic        MDRin;
  logic        read;
  logic [31:0] BMout;
  logic [31:0] Mdatain;
  logic        start_rd;
  logic        start_wr;
  logic [1:0]  size;
  logic        sign_ext;
  logic [1:0]  addr_lo;
  logic        mem_ready;
  logic [31:0] BMInMDR;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rd_req;
  logic        mem_wr_req;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;

  mdr_mem_if #(
    .DATA_W    (32),
    .RESET_VAL (32'h0000_0002),
    .MAX_WAIT  (15)
  ) dut (
    .clock      (clock),
    .clear      (clear),
    .MDRin      (MDRin),
    .read       (read),
    .BMout      (BMout),
    .Mdatain    (Mdatain),
    .start_rd   (start_rd),
    .start_wr   (start_wr),
    .size       (size),
    .sign_ext   (sign_ext),
    .addr_lo    (addr_lo),
    .mem_ready  (mem_ready),
    .BMInMDR    (BMInMDR),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_rd_req (mem_rd_req),
    .mem_wr_req (mem_wr_req),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b0; MDRin = 1'b0; read = 1'b0; BMout = '0; Mdatain = '0;
    start_rd = 1'b0; start_wr = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr_lo = 2'b00; mem_ready = 1'b0;
    tick(); tick();
    n_checks++;
    if (BMInMDR !== 32'h0000_0002) $display("[TB] FAIL reset_reg: got %h expected %h", BMInMDR, 32'h2);
    else n_pass++;
    n_checks++;
    if ({busy, err, done, mem_rd_req, mem_wr_req} !== 5'b0)
      $display("[TB] FAIL reset_flags: got %b expected %b", {busy, err, done, mem_rd_req, mem_wr_req}, 5'b0);
    else n_pass++;
    n_checks++;
    if (mem_be !== 4'b0000) $display("[TB] FAIL reset_be: got %b expected %b", mem_be, 4'b0);
    else n_pass++;
    clear = 1'b1;
    tick();
    MDRin = 1'b1; read = 1'b0; BMout = 32'hDEAD_BEEF; Mdatain = 32'h1111_1111;
    tick();
    MDRin = 1'b0;
    n_checks++;
    if (BMInMDR !== 32'hDEAD_BEEF) $display("[TB] FAIL legacy_load_bus: got %h expected %h", BMInMDR, 32'hDEAD_BEEF);
    else n_pass++;
    MDRin = 1'b1; read = 1'b1;
    tick();
    MDRin = 1'b0; read = 1'b0;
    n_checks++;
    if (BMInMDR !== 32'h1111_1111) $display("[TB] FAIL legacy_load_mem: got %h expected %h", BMInMDR, 32'h1111_1111);
    else n_pass++;
  endtask

  task automatic test_byte_load(input logic sx, input logic [31:0] expected);
    int  busy_cycles;
    logic early_done;
    busy_cycles = 0;
    early_done  = 1'b0;
    size = 2'b00; sign_ext = sx; addr_lo = 2'd2; start_rd = 1'b1;
    Mdatain = 32'h0080_0000; mem_ready = 1'b0;
    tick();
    start_rd = 1'b0;
    // Later changes to the access attributes must be ignored
    size = 2'b10; sign_ext = ~sx; addr_lo = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (busy) busy_cycles++;
      if (done) early_done = 1'b1;
      tick();
    end
    mem_ready = 1'b1;
    if (busy) busy_cycles++;
    n_checks++;
    if (mem_rd_req !== 1'b1) $display("[TB] FAIL byte_load_req: got %b expected %b", mem_rd_req, 1'b1);
    else n_pass++;
    tick();
    mem_ready = 1'b0;
    n_checks++;
    if (busy_cycles !== 4 || early_done) $display("[TB] FAIL byte_load_busy: got %0d/%b expected %0d/%b", busy_cycles, early_done, 4, 1'b0);
    else n_pass++;
    n_checks++;
    if (BMInMDR !== expected) $display("[TB] FAIL byte_load_value: got %h expected %h", BMInMDR, expected);
    else n_pass++;
    n_checks++;
    if ({done, busy, mem_rd_req} !== 3'b100) $display("[TB] FAIL byte_load_done: got %b expected %b", {done, busy, mem_rd_req}, 3'b100);
    else n_pass++;
    tick();
    n_checks++;
    if (done !== 1'b0) $display("[TB] FAIL byte_load_done_pulse: got %b expected %b", done, 1'b0);
    else n_pass++;
  endtask

  task automatic test_half_load();
    size = 2'b01; sign_ext = 1'b1; addr_lo = 2'd0; start_rd = 1'b1;
    Mdatain = 32'h1234_8001; mem_ready = 1'b0;
    tick();
    start_rd = 1'b0; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    n_checks++;
    if (BMInMDR !== 32'hFFFF_8001) $display("[TB] FAIL half_load_signed: got %h expected %h", BMInMDR, 32'hFFFF_8001);
    else n_pass++;
  endtask

  task automatic test_half_store();
    logic stable;
    stable = 1'b1;
    MDRin = 1'b1; read = 1'b0; BMout = 32'h0000_ABCD;
    tick();
    MDRin = 1'b0;
    size = 2'b01; addr_lo = 2'd2; start_wr = 1'b1; mem_ready = 1'b0;
    tick();
    start_wr = 1'b0; size = 2'b00; addr_lo = 2'd1;
    for (int i = 0; i < 3; i++) begin
      if (mem_wdata !== 32'hABCD_ABCD || mem_be !== 4'b1100 || mem_wr_req !== 1'b1 || mem_rd_req !== 1'b0)
        stable = 1'b0;
      if (i == 2) mem_ready = 1'b1;
      tick();
    end
    mem_ready = 1'b0;
    n_checks++;
    if (!stable) $display("[TB] FAIL half_store_stable: got %h/%b expected %h/%b", mem_wdata, mem_be, 32'hABCD_ABCD, 4'b1100);
    else n_pass++;
    n_checks++;
    if ({done, mem_wr_req, mem_be} !== {1'b1, 1'b0, 4'b0000})
      $display("[TB] FAIL half_store_end: got %b expected %b", {done, mem_wr_req, mem_be}, 6'b100000);
    else n_pass++;
    n_checks++;
    if (BMInMDR !== 32'h0000_ABCD) $display("[TB] FAIL half_store_reg: got %h expected %h", BMInMDR, 32'h0000_ABCD);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int   busy_cycles;
    logic saw_done;
    busy_cycles = 0;
    saw_done    = 1'b0;
    size = 2'b10; addr_lo = 2'd0; start_rd = 1'b1; mem_ready = 1'b0; Mdatain = 32'h5555_5555;
    tick();
    start_rd = 1'b0;
    while (busy && busy_cycles < 40) begin
      busy_cycles++;
      if (done) saw_done = 1'b1;
      tick();
    end
    if (done) saw_done = 1'b1;
    n_checks++;
    if (busy_cycles !== 15) $display("[TB] FAIL timeout_cycles: got %0d expected %0d", busy_cycles, 15);
    else n_pass++;
    n_checks++;
    if ({err, saw_done, busy} !== 3'b100) $display("[TB] FAIL timeout_flags: got %b expected %b", {err, saw_done, busy}, 3'b100);
    else n_pass++;
    n_checks++;
    if (BMInMDR !== 32'h0000_ABCD) $display("[TB] FAIL timeout_reg: got %h expected %h", BMInMDR, 32'h0000_ABCD);
    else n_pass++;
    size = 2'b11; addr_lo = 2'd0; start_wr = 1'b1;
    tick();
    start_wr = 1'b0;
    n_checks++;
    if ({err, mem_wr_req} !== 2'b01) $display("[TB] FAIL timeout_err_clear: got %b expected %b", {err, mem_wr_req}, 2'b01);
    else n_pass++;
    n_checks++;
    if (mem_wdata !== 32'h0000_ABCD || mem_be !== 4'b1111)
      $display("[TB] FAIL word_store: got %h/%b expected %h/%b", mem_wdata, mem_be, 32'h0000_ABCD, 4'b1111);
    else n_pass++;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_misaligned_priority();
    size = 2'b01; addr_lo = 2'd1; start_rd = 1'b1;
    tick();
    start_rd = 1'b0;
    n_checks++;
    if ({err, mem_rd_req, busy} !== 3'b100) $display("[TB] FAIL misaligned: got %b expected %b", {err, mem_rd_req, busy}, 3'b100);
    else n_pass++;
    n_checks++;
    if (BMInMDR !== 32'h0000_ABCD) $display("[TB] FAIL misaligned_reg: got %h expected %h", BMInMDR, 32'h0000_ABCD);
    else n_pass++;
    size = 2'b10; addr_lo = 2'd0;
    start_rd = 1'b1; start_wr = 1'b1; MDRin = 1'b1; read = 1'b0; BMout = 32'h1111_2222;
    tick();
    start_rd = 1'b0; start_wr = 1'b0;
    n_checks++;
    if ({mem_rd_req, mem_wr_req, err} !== 3'b100) $display("[TB] FAIL priority: got %b expected %b", {mem_rd_req, mem_wr_req, err}, 3'b100);
    else n_pass++;
    n_checks++;
    if (BMInMDR !== 32'h0000_ABCD) $display("[TB] FAIL priority_reg: got %h expected %h", BMInMDR, 32'h0000_ABCD);
    else n_pass++;
    BMout = 32'h3333_4444;
    tick();
    MDRin = 1'b0;
    n_checks++;
    if (BMInMDR !== 32'h0000_ABCD) $display("[TB] FAIL busy_mdrin: got %h expected %h", BMInMDR, 32'h0000_ABCD);
    else n_pass++;
    Mdatain = 32'hCAFE_F00D; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    n_checks++;
    if (BMInMDR !== 32'hCAFE_F00D || done !== 1'b1) $display("[TB] FAIL word_load: got %h/%b expected %h/%b", BMInMDR, done, 32'hCAFE_F00D, 1'b1);
    else n_pass++;
    tick();
  endtask

  task automatic test_async_reset();
    logic saw_done;
    saw_done = 1'b0;
    size = 2'b10; addr_lo = 2'd0; start_wr = 1'b1; mem_ready = 1'b0;
    tick();
    start_wr = 1'b0;
    n_checks++;
    if (mem_wr_req !== 1'b1) $display("[TB] FAIL async_pre_req: got %b expected %b", mem_wr_req, 1'b1);
    else n_pass++;
    #2;
    clear = 1'b0;
    #1;
    n_checks++;
    if ({mem_wr_req, busy, mem_be} !== 6'b0) $display("[TB] FAIL async_drop: got %b expected %b", {mem_wr_req, busy, mem_be}, 6'b0);
    else n_pass++;
    n_checks++;
    if (BMInMDR !== 32'h0000_0002) $display("[TB] FAIL async_reg: got %h expected %h", BMInMDR, 32'h2);
    else n_pass++;
    tick();
    clear = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    mem_ready = 1'b0;
    n_checks++;
    if (saw_done !== 1'b0) $display("[TB] FAIL async_no_done: got %b expected %b", saw_done, 1'b0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_byte_load(1'b1, 32'hFFFF_FF80);
    test_byte_load(1'b0, 32'h0000_0080);
    test_half_load();
    test_half_store();
    test_timeout();
    test_misaligned_priority();
    test_async_reset();
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
